vector_sequencer: RTL and testbench

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_pkg.sv | 13 +
 rtl/vec_elem_counter.sv | 46 ++++
 rtl/vector_sequencer.sv | 86 ++++++++
 tb/tb_vector_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared constants and the state encoding for the vector element sequencer.
package vector_pkg;

   localparam int unsigned MAX_VL_DEF     = 8;
   localparam logic [6:0]  VEC_OPCODE_DEF = 7'b1010111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/vec_elem_counter.sv
// Element index counter with a latched limit; tc_o flags the last element of the vector.
module vec_elem_counter
   import vector_pkg::*;
#(
   parameter  int unsigned MAX_VL = MAX_VL_DEF,
   localparam int unsigned IW     = $clog2(MAX_VL),
   localparam int unsigned VLW    = $clog2(MAX_VL + 1)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic [VLW-1:0] vl_i,
   input  logic           en_i,
   output logic [IW-1:0]  idx_o,
   output logic           tc_o
);

   logic [IW-1:0]  idx_q, idx_d;
   logic [VLW-1:0] lim_q, lim_d;

   always_comb begin
      idx_d = idx_q;
      lim_d = lim_q;
      if (load_i) begin
         idx_d = '0;
         lim_d = vl_i;
      end else if (en_i) begin
         idx_d = idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         lim_q <= '0;
      end else begin
         idx_q <= idx_d;
         lim_q <= lim_d;
      end
   end

   assign idx_o = idx_q;
   // Widened compare avoids wrap when the limit equals MAX_VL.
   assign tc_o  = ((VLW'(idx_q) + VLW'(1)) == lim_q);

endmodule

// File: rtl/vector_sequencer.sv
// Sequences a vector instruction element by element onto a shared ALU, stalling decode meanwhile.
module vector_sequencer
   import vector_pkg::*;
#(
   parameter  int unsigned MAX_VL     = MAX_VL_DEF,
   parameter  logic [6:0]  VEC_OPCODE = VEC_OPCODE_DEF,
   localparam int unsigned IW         = $clog2(MAX_VL),
   localparam int unsigned VLW        = $clog2(MAX_VL + 1)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           issue_valid_i,
   input  logic [6:0]     Op_i,
   input  logic [VLW-1:0] vl_i,
   input  logic           alu_ready_i,
   input  logic           flush_i,
   output logic           issue_ready_o,
   output logic           stall_o,
   output logic           elem_valid_o,
   output logic [IW-1:0]  elem_idx_o,
   output logic           wb_en_o,
   output logic           done_o
);

   state_e         state_q, state_d;
   logic           vec_issue;
   logic           cnt_load;
   logic           cnt_en;
   logic           cnt_tc;
   logic [IW-1:0]  cnt_idx;
   logic [VLW-1:0] vl_clamp;

   assign vec_issue = issue_valid_i && (Op_i == VEC_OPCODE);
   assign vl_clamp  = (vl_i > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl_i;

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (vec_issue && !flush_i) begin
               if (vl_i != '0) begin
                  cnt_load = 1'b1;
                  state_d  = EXEC;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         EXEC: begin
            if (alu_ready_i && cnt_tc) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Flush wins over both a new issue and a final-element completion.
      if (flush_i) state_d = IDLE;
   end

   assign cnt_en = (state_q == EXEC) && alu_ready_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   vec_elem_counter #(
      .MAX_VL (MAX_VL)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (cnt_load),
      .vl_i   (vl_clamp),
      .en_i   (cnt_en),
      .idx_o  (cnt_idx),
      .tc_o   (cnt_tc)
   );

   assign issue_ready_o = (state_q == IDLE);
   assign stall_o       = (state_q == EXEC);
   assign elem_valid_o  = (state_q == EXEC);
   assign elem_idx_o    = (state_q == EXEC) ? cnt_idx : '0;
   assign wb_en_o       = elem_valid_o && alu_ready_i;
   assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed checks of the vector sequencer: issue, ALU backpressure, clamping, flush and reset.
module tb_vector_sequencer;

   localparam int unsigned MAX_VL = 8;
   localparam int unsigned IW     = 3;
   localparam int unsigned VLW    = 4;
   localparam logic [6:0]  VOP    = 7'b1010111;
   localparam logic [6:0]  ROP    = 7'b0110011;
   localparam logic [7:0]  O_IDLE = 8'b1000_0000;
   localparam logic [7:0]  O_DONE = 8'b0000_1000;

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic           issue_valid_i = 1'b0;
   logic [6:0]     Op_i = '0;
   logic [VLW-1:0] vl_i = '0;
   logic           alu_ready_i = 1'b0;
   logic           flush_i = 1'b0;
   logic           issue_ready_o, stall_o, elem_valid_o, wb_en_o, done_o;
   logic [IW-1:0]  elem_idx_o;
   logic [7:0]     obs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vector_sequencer #(
      .MAX_VL     (MAX_VL),
      .VEC_OPCODE (VOP)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .issue_valid_i (issue_valid_i),
      .Op_i          (Op_i),
      .vl_i          (vl_i),
      .alu_ready_i   (alu_ready_i),
      .flush_i       (flush_i),
      .issue_ready_o (issue_ready_o),
      .stall_o       (stall_o),
      .elem_valid_o  (elem_valid_o),
      .elem_idx_o    (elem_idx_o),
      .wb_en_o       (wb_en_o),
      .done_o        (done_o)
   );

   // {issue_ready, stall, elem_valid, wb_en, done, idx[2:0]}
   assign obs = {issue_ready_o, stall_o, elem_valid_o, wb_en_o, done_o, elem_idx_o};

   function automatic logic [7:0] o_exec(input logic wb, input int unsigned idx);
      logic [2:0] i3;
      i3 = idx[2:0];
      return {1'b0, 1'b1, 1'b1, wb, 1'b0, i3};
   endfunction

   // Apply inputs mid-cycle; outputs are then sampled 1 time unit later, well away from posedge.
   task automatic drive(input logic iv, input logic [6:0] op, input logic [VLW-1:0] vl,
                        input logic rdy, input logic fl, input logic rs);
      @(negedge clk);
      issue_valid_i = iv;
      Op_i          = op;
      vl_i          = vl;
      alu_ready_i   = rdy;
      flush_i       = fl;
      rst_i         = rs;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, VOP, 4'd4, 1'b1, 1'b0, 1'b1);
      drive(1'b1, VOP, 4'd4, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, O_IDLE); end
      drive(1'b0, VOP, 4'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_basic();
      drive(1'b1, VOP, 4'd4, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL basic_issue: got %b expected %b", obs, O_IDLE); end
      for (int unsigned i = 0; i < 4; i++) begin
         drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== o_exec(1'b1, i)) begin
            n_fail++; $display("FAIL basic_elem[%0d]: got %b expected %b", i, obs, o_exec(1'b1, i));
         end
      end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_DONE) begin n_fail++; $display("FAIL basic_done: got %b expected %b", obs, O_DONE); end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL basic_idle: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_backpressure();
      logic        rdy_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int unsigned idx_t [4] = '{0, 1, 1, 2};
      drive(1'b1, VOP, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 4; i++) begin
         drive(1'b0, VOP, 4'd0, rdy_t[i], 1'b0, 1'b0);
         n_checks++;
         if (obs !== o_exec(rdy_t[i], idx_t[i])) begin
            n_fail++; $display("FAIL bp_elem[%0d]: got %b expected %b", i, obs, o_exec(rdy_t[i], idx_t[i]));
         end
      end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_DONE) begin n_fail++; $display("FAIL bp_done: got %b expected %b", obs, O_DONE); end
      drive(1'b0, VOP, 4'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL bp_idle: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_zero_vl();
      drive(1'b1, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_DONE) begin n_fail++; $display("FAIL zero_done: got %b expected %b", obs, O_DONE); end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL zero_idle: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_clamp();
      drive(1'b1, VOP, 4'd15, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 8; i++) begin
         drive(1'b0, VOP, 4'd15, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== o_exec(1'b1, i)) begin
            n_fail++; $display("FAIL clamp_elem[%0d]: got %b expected %b", i, obs, o_exec(1'b1, i));
         end
      end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_DONE) begin n_fail++; $display("FAIL clamp_done: got %b expected %b", obs, O_DONE); end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      // flush at idx 2 of a 6-element vector
      drive(1'b1, VOP, 4'd6, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs !== o_exec(1'b1, 2)) begin n_fail++; $display("FAIL flush_at_idx2: got %b expected %b", obs, o_exec(1'b1, 2)); end
      for (int unsigned i = 0; i < 2; i++) begin
         drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== O_IDLE) begin n_fail++; $display("FAIL flush_idle[%0d]: got %b expected %b", i, obs, O_IDLE); end
      end
      // reset at idx 1 behaves the same
      drive(1'b1, VOP, 4'd6, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b1);
      for (int unsigned i = 0; i < 2; i++) begin
         drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== O_IDLE) begin n_fail++; $display("FAIL rst_idle[%0d]: got %b expected %b", i, obs, O_IDLE); end
      end
      // flush on the final element beats completion
      drive(1'b1, VOP, 4'd2, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL flush_last: got %b expected %b", obs, O_IDLE); end
      // flush alongside an issue discards it
      drive(1'b1, VOP, 4'd3, 1'b1, 1'b1, 1'b0);
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL flush_issue: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_nonvec();
      for (int unsigned i = 0; i < 3; i++) begin
         drive(1'b1, ROP, 4'd4, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== O_IDLE) begin n_fail++; $display("FAIL nonvec[%0d]: got %b expected %b", i, obs, O_IDLE); end
      end
      drive(1'b0, ROP, 4'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== O_IDLE) begin n_fail++; $display("FAIL nonvec_after: got %b expected %b", obs, O_IDLE); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_t [6];
      exp_t = '{O_IDLE, o_exec(1'b1, 0), O_DONE, O_IDLE, o_exec(1'b1, 0), O_DONE};
      for (int unsigned i = 0; i < 6; i++) begin
         drive((i == 0 || i == 3) ? 1'b1 : 1'b0, VOP, 4'd1, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs !== exp_t[i]) begin n_fail++; $display("FAIL b2b[%0d]: got %b expected %b", i, obs, exp_t[i]); end
      end
      drive(1'b0, VOP, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_vl();
      test_clamp();
      test_flush();
      test_nonvec();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
